// File: rtl/puf_pkg.sv
// puf_pkg: shared FSM state type and default width for the PUF window counter
package puf_pkg;
  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
  localparam int PUF_DEFAULT_WIDTH = 22;
endpackage

// File: rtl/puf_sat_counter.sv
// puf_sat_counter: clearable event counter that holds at all-ones and flags saturation
module puf_sat_counter #(
  parameter int WIDTH = 22
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             sat_o
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             sat_q;
  assign cnt_d = clr_i ? '0 : (en_i && cnt_q != '1) ? cnt_q + ONE : cnt_q;
  // the flag follows the held all-ones value, so it persists until the next clear
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= !clr_i && cnt_d == '1;
    end
  assign cnt_o = cnt_q;
  assign sat_o = sat_q;
endmodule

// File: rtl/puf_window_counter.sv
// puf_window_counter: counts per-channel events over a goal-cycle window; PUF_COMPARE_EN adds the ch0>ch1 response bit
module puf_window_counter
  import puf_pkg::*;
#(
  parameter int WIDTH    = PUF_DEFAULT_WIDTH,
  parameter int CHANNELS = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [WIDTH-1:0]          goal,
  input  logic [CHANNELS-1:0]       event_en,
  output logic                      busy,
  output logic                      done,
  output logic [CHANNELS*WIDTH-1:0] counts,
  output logic [CHANNELS-1:0]       saturated,
  output logic                      response
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  state_t           state_q;
  logic [WIDTH-1:0] goal_q, win_q;
  logic             accept, last;
  assign accept = state_q == IDLE && start;
  assign last   = state_q == COUNT && win_q == goal_q - ONE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      goal_q  <= '0;
      win_q   <= '0;
    end else if (accept) begin
      state_q <= goal == '0 ? DONE : COUNT;
      goal_q  <= goal;
      win_q   <= '0;
    end else if (state_q == COUNT) begin
      win_q <= win_q + ONE;
      if (last) state_q <= DONE;
    end else if (state_q == DONE) begin
      state_q <= IDLE;
    end
  assign busy = state_q == COUNT;
  assign done = state_q == DONE;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    puf_sat_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk    (clk),
      .reset_n(reset_n),
      .clr_i  (accept),
      .en_i   (state_q == COUNT && event_en[i]),
      .cnt_o  (counts[i*WIDTH +: WIDTH]),
      .sat_o  (saturated[i])
    );
  end
`ifdef PUF_COMPARE_EN
  logic             resp_q;
  logic [WIDTH-1:0] c0_n, c1_n;
  // compare the values the counters take on entry to DONE, including the final cycle's events
  assign c0_n = counts[0 +: WIDTH] + WIDTH'(event_en[0] && counts[0 +: WIDTH] != '1);
  assign c1_n = counts[WIDTH +: WIDTH] + WIDTH'(event_en[1] && counts[WIDTH +: WIDTH] != '1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) resp_q <= 1'b0;
    else if (accept) resp_q <= 1'b0;
    else if (last) resp_q <= c0_n > c1_n;
  assign response = resp_q;
`else
  assign response = 1'b0;
`endif
endmodule

// File: tb/tb_puf_window_counter.sv
// tb_puf_window_counter: directed and random windows checked against an event-sum model
module tb_puf_window_counter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [21:0] goal = '0;
  logic [3:0]  goal4;
  logic [1:0]  event_en = '0;
  logic        busy, done, response, busy4, done4, response4;
  logic [43:0] counts;
  logic [7:0]  counts4;
  logic [1:0]  saturated, sat4;
  int total = 0;
  int bad = 0;

  assign goal4 = goal[3:0];

  puf_window_counter #(.WIDTH(22), .CHANNELS(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .goal(goal), .event_en(event_en),
    .busy(busy), .done(done), .counts(counts), .saturated(saturated), .response(response)
  );

  puf_window_counter #(.WIDTH(4), .CHANNELS(2)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start), .goal(goal4), .event_en(event_en),
    .busy(busy4), .done(done4), .counts(counts4), .saturated(sat4), .response(response4)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic resp_model(input int a, input int b);
`ifdef PUF_COMPARE_EN
    return a > b;
`else
    return 1'b0;
`endif
  endfunction

  // mode 0: both channels always on, 1: ch0 always / ch1 alternate, 2: random, 3: ch0 only
  task automatic run_window(input int g, input int mode, input bit restart, input bit chk4);
    int m0 = 0;
    int m1 = 0;
    int s4;
    logic [1:0] ev;
    goal = 22'(g);
    start = 1'b1;
    tick();
    start = 1'b0;
    goal = 22'($urandom);
    for (int k = 1; k <= g; k++) begin
      ev = mode == 0 ? 2'b11 : mode == 1 ? {1'(k % 2), 1'b1} : mode == 2 ? 2'($urandom) : 2'b01;
      event_en = ev;
      m0 += int'(ev[0]);
      m1 += int'(ev[1]);
      start = restart && k == 3;
      if (restart && k == 3) goal = 22'(g + 7);
      chk("busy_in_window", 32'(busy), 1);
      chk("done_in_window", 32'(done), 0);
      if (chk4 && k == 1) begin
        chk("sat4_cleared", 32'(sat4[0]), 0);
        chk("cnt4_cleared", 32'(counts4[3:0]), 0);
      end
      tick();
    end
    start = 1'b0;
    event_en = 2'($urandom);
    chk("done_at_end", 32'(done), 1);
    chk("busy_at_end", 32'(busy), 0);
    chk("count0", 32'(counts[21:0]), 32'(m0));
    chk("count1", 32'(counts[43:22]), 32'(m1));
    chk("saturated", 32'(saturated), 0);
    chk("response", 32'(response), 32'(resp_model(m0, m1)));
    if (chk4) begin
      s4 = m0 > 15 ? 15 : m0;
      chk("done4", 32'(done4), 1);
      chk("busy4", 32'(busy4), 0);
      chk("count4_0", 32'(counts4[3:0]), 32'(s4));
      chk("count4_1", 32'(counts4[7:4]), 0);
      chk("sat4_0", 32'(sat4[0]), 32'(s4 == 15));
      chk("sat4_1", 32'(sat4[1]), 0);
      chk("response4", 32'(response4), 32'(resp_model(s4, 0)));
    end
    tick();
    chk("done_one_cycle", 32'(done), 0);
    chk("busy_after", 32'(busy), 0);
    chk("count0_stable", 32'(counts[21:0]), 32'(m0));
    chk("count1_stable", 32'(counts[43:22]), 32'(m1));
    chk("response_stable", 32'(response), 32'(resp_model(m0, m1)));
  endtask

  initial begin
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_counts", 32'(counts[21:0] | counts[43:22]), 0);
    chk("rst_sat", 32'(saturated), 0);
    chk("rst_response", 32'(response), 0);
    tick();
    reset_n = 1'b1;
    tick();

    run_window(10, 0, 1'b0, 1'b0);
    run_window(100, 1, 1'b0, 1'b0);
    run_window(15, 3, 1'b0, 1'b1);
    run_window(5, 3, 1'b0, 1'b1);

    goal = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("g0_done", 32'(done), 1);
    chk("g0_busy", 32'(busy), 0);
    chk("g0_counts", 32'(counts[21:0] | counts[43:22]), 0);
    chk("g0_response", 32'(response), 0);
    tick();
    chk("g0_done_off", 32'(done), 0);
    chk("g0_busy_off", 32'(busy), 0);

    run_window(30, 2, 1'b1, 1'b0);
    for (int r = 0; r < 4; r++) run_window(int'($urandom_range(40, 1)), 2, 1'b0, 1'b0);

    goal = 22'd20;
    start = 1'b1;
    tick();
    start = 1'b0;
    event_en = 2'b11;
    for (int k = 1; k < 5; k++) tick();
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_counts", 32'(counts[21:0] | counts[43:22]), 0);
    chk("abort_sat", 32'(saturated), 0);
    chk("abort_response", 32'(response), 0);
    tick();
    chk("abort_no_done", 32'(done), 0);
    tick();
    reset_n = 1'b1;
    run_window(20, 2, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/puf_window_counter.md
PUF_WINDOW_COUNTER -- requirements
Module: puf_window_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 22, the bit width of the window counter and of each channel counter.
REQ-002 The block SHALL have parameter CHANNELS, default 2, the number of event channels; legal range is 2..16.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, a request to begin a measurement window.
REQ-006 The block SHALL have port goal, input, WIDTH, the window length in clk cycles.
REQ-007 The block SHALL have port event_en, input, CHANNELS, per-channel count enables, already synchronous to clk.
REQ-008 The block SHALL have port busy, output, 1, high while a window is in progress.
REQ-009 The block SHALL have port done, output, 1, a one-cycle pulse marking the end of a window.
REQ-010 The block SHALL have port counts, output, CHANNELS*WIDTH, the packed channel counts, with channel i at bits [i*WIDTH +: WIDTH].
REQ-011 The block SHALL have port saturated, output, CHANNELS, per-channel saturation flags.
REQ-012 The block SHALL have port response, output, 1, the PUF response bit.

Function
REQ-013 The FSM SHALL have three states, IDLE, COUNT and DONE; busy=1 only in COUNT, and done=1 only in DONE.
REQ-014 start SHALL be accepted only in IDLE; start in COUNT or DONE SHALL be ignored, with no queuing.
REQ-015 On acceptance, the block SHALL latch goal, clear all channel counts, saturated and the window counter, and move to COUNT.
- Later changes on goal SHALL be ignored until the next acceptance.
REQ-016 If the latched goal is 0, the block SHALL go IDLE->DONE directly: done one cycle after acceptance, all counts 0.
REQ-017 In COUNT, the window counter SHALL increment by 1 every cycle.
- In each COUNT cycle, channel i SHALL increment when event_en[i]=1.
- The block SHALL leave COUNT after exactly goal COUNT cycles.
REQ-018 Timing: if start is accepted in cycle t, event_en SHALL be sampled in cycles t+1..t+goal, and done SHALL be high in cycle t+goal+1 only.
REQ-019 DONE SHALL last exactly one cycle and then return unconditionally to IDLE.
REQ-020 A channel counter at all-ones SHALL hold its value, not wrap, and set saturated[i]=1 until the next acceptance.
REQ-021 counts, saturated and response SHALL stay stable from DONE until the next accepted start.
REQ-022 The window counter SHALL be WIDTH bits and compare against goal-1; the maximum goal of 2^WIDTH-1 SHALL be supported without overflow.

Reset
REQ-023 While reset_n=0, the block SHALL force: state IDLE, busy=0, done=0, counts all 0, saturated all 0, response=0, and latched goal 0.
REQ-024 Reset asserted mid-window SHALL abort the window immediately, with no done pulse.
- After release, the block SHALL accept start in the first cycle.

Configuration
REQ-025 Macro PUF_COMPARE_EN SHALL control the response comparator.
- Defined: response SHALL be registered on entry to DONE as 1 if count[0] > count[1] (unsigned), else 0; ties give 0.
REQ-026 Undefined: response SHALL be tied to 0, and no comparator logic SHALL be synthesised.

Structure
REQ-027 Shared package puf_pkg SHALL hold the FSM state typedef (IDLE/COUNT/DONE) and the constant PUF_DEFAULT_WIDTH = 22.
REQ-028 The per-channel counter SHALL be a sub-module, puf_sat_counter, with clear, enable, saturating count and a sat flag, instantiated CHANNELS times.

Verification
REQ-029 The bench SHALL cover all of the following directed scenarios:
- goal=10, event_en=2'b11 held high, start pulsed once: busy high 10 cycles, done 11 cycles after start, counts={10,10}, response=0.
- goal=100, channel 0 enabled every cycle, channel 1 every other cycle: counts={100,50}, response=1 with PUF_COMPARE_EN defined, 0 without.
- WIDTH=4, goal=15, event_en[0] high: count[0]=15, saturated[0]=1, no wrap; a second window clears the flag.
- goal=0: done one cycle after start, counts 0, busy never high; start repeated during COUNT is ignored and the window length is unchanged.
- reset_n asserted at cycle 5 of a goal=20 window: outputs zero immediately, no done pulse; start right after release runs a full 20-cycle window.
